serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Multi-cycle add/subtract controller that computes WIDTH-bit sums with a single 4-bit ripple adder slice (FullAdder4), one nibble per clock.
- Latches operands, steps the slice from LSB nibble to MSB nibble, carries between steps through a register, and reports result and flags.
- Sits in the 32-bit ALU as the area-reduced add/sub path, driven by the ALU control with a start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8
STEPS, WIDTH/4, number of slice iterations; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when ready=1
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ready  output  1  1 when IDLE and able to accept start
done  output  1  one-cycle pulse; result and flags valid this cycle and held afterwards
result  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  carry out of the MSB slice (sub: 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  result == 0

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, done=0, result=0, cout=0, overflow=0, zero=1; nibble counter=0, carry reg=0, operand regs=0. Asserting rst mid-RUN aborts the operation; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1:
  - latch opA=a and opB = sub ? ~b : b;
  - carry reg = sub; counter=0;
  - go to RUN; ready falls next cycle.
- RUN: ready=0. Each cycle:
  - drive the slice with opA[4k+3:4k], opB[4k+3:4k] and the carry reg, where k = counter;
  - write the slice sum into result[4k+3:4k];
  - carry reg <= slice cOut; counter++.
  - When counter == STEPS-1, the final nibble is written this cycle:
    - cout <= slice cOut;
    - overflow <= carry into MSB bit XOR carry out of MSB bit, computed as (opA[W-1] == opB[W-1]) && (sum[W-1] != opA[W-1]) on the final nibble;
    - go to DONE.
- DONE: done=1 for exactly one cycle; zero reflects the complete result; next state IDLE (ready=1 the following cycle).
- Latency: start sampled at edge N, done=1 during the cycle after edge N+STEPS+1, i.e. STEPS+1 cycles after the accepting edge. Back-to-back throughput is one operation per STEPS+2 cycles.
- Start while ready=0 (RUN or DONE) is ignored; it is not queued. Changes on a, b or sub after acceptance have no effect.
- result, cout, overflow and zero hold their last completed values while IDLE.
- During RUN, result is partially updated. Consumers use it only when done=1 or ready=1 after a completed operation.
- Simultaneous rst and start: rst wins; the request is dropped.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement: a + ~b + 1.

Test Plan:
- rst pulse mid-RUN (after 3 steps) -> immediate IDLE, ready=1, done never pulses, result=0, zero=1.
- start, sub=0, a=0x0000_0005, b=0x0000_0003 -> done exactly 9 cycles after the accept edge; result=0x0000_0008, cout=0, overflow=0, zero=0.
- Carry ripple through all nibbles: sub=0, a=0xFFFF_FFFF, b=0x0000_0001 -> result=0, cout=1, overflow=0, zero=1.
- Signed overflow: sub=0, a=0x7FFF_FFFF, b=0x0000_0001 -> result=0x8000_0000, overflow=1, cout=0. Also sub=1, a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, overflow=1, cout=1.
- Subtract with borrow: sub=1, a=3, b=5 -> result=0xFFFF_FFFE, cout=0, overflow=0; and a=b=0x1234_5678 -> result=0, zero=1, cout=1.
- start held high continuously with a, b changing every cycle -> only the values present on ready=1 edges are accepted; done pulses once per 10 cycles; the second result matches the operands sampled at the second accept.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Area-reduced add/sub path: one 4-bit ripple slice stepped LSB->MSB nibble per clock,
// with a start/done handshake toward the ALU control.
module full_adder4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int STEPS = WIDTH / 4;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa, opb;
    logic [CW+1:0]    idx;
    logic [3:0]       nib_s;
    logic             nib_co;
    logic             last;

    assign idx   = {cnt, 2'b00};
    assign last  = (cnt == CW'(STEPS - 1));
    assign ready = (state == IDLE);

    full_adder4 u_slice (
        .x   (opa[idx +: 4]),
        .y   (opb[idx +: 4]),
        .cin (carry),
        .s   (nib_s),
        .co  (nib_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // done is registered out of DONE so it lines up with the freshly computed zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    opa   <= a;
                    opb   <= sub ? ~b : b;
                    carry <= sub;
                    cnt   <= '0;
                end
                RUN: begin
                    result[idx +: 4] <= nib_s;
                    carry            <= nib_co;
                    cnt              <= cnt + CW'(1);
                    if (last) begin
                        cout     <= nib_co;
                        overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) && (nib_s[3] != opa[WIDTH-1]);
                    end
                end
                DONE: begin
                    zero <= (result == '0);
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
